// File: rtl/de2_115_sopc_sysid_checker_pkg.sv
// de2_115_sopc_sysid_checker_pkg: shared state encoding, sysid word addresses
// and the build-time expected sysid values.
`default_nettype none

package de2_115_sopc_sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_ID  = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_REQ_TS  = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1354258592;

endpackage

`default_nettype wire

// File: rtl/de2_115_sopc_sysid_checker_timer.sv
// de2_115_sopc_sysid_checker_timer: per-transaction cycle counter with
// terminal count, plus a per-word retry counter with limit compare.
`default_nettype none

module de2_115_sopc_sysid_checker_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic cnt_clear,
  input  logic cnt_en,
  input  logic retry_clear,
  input  logic retry_inc,
  output logic expired,
  output logic exhausted
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    retries;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt_clear) begin
      cnt <= '0;
    end else if (cnt_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retries <= '0;
    end else if (retry_clear) begin
      retries <= '0;
    end else if (retry_inc) begin
      retries <= retries + 1'b1;
    end
  end

  // cnt holds (cycle index - 1) within the transaction, so LIMIT marks its last cycle.
  assign expired   = (cnt >= LIMIT);
  assign exhausted = (retries == 4'(MAX_RETRIES));

endmodule

`default_nettype wire

// File: rtl/de2_115_sopc_sysid_checker.sv
// de2_115_sopc_sysid_checker: boot-time Avalon-MM master that reads the sysid
// ID and timestamp words and flags pass, mismatch or timeout.
`default_nettype none

module de2_115_sopc_sysid_checker
  import de2_115_sopc_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  state_t state, state_d;
  logic   auto_start;
  logic   expired, exhausted;
  logic   cnt_clear, cnt_en, retry_clear, retry_inc;
  logic   id_mis_d, ts_mis_d, timeout_d, cap_id, cap_ts;

  de2_115_sopc_sysid_checker_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .cnt_clear  (cnt_clear),
    .cnt_en     (cnt_en),
    .retry_clear(retry_clear),
    .retry_inc  (retry_inc),
    .expired    (expired),
    .exhausted  (exhausted)
  );

  always_comb begin
    state_d     = state;
    id_mis_d    = id_mismatch;
    ts_mis_d    = ts_mismatch;
    timeout_d   = timeout;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    retry_clear = 1'b0;
    retry_inc   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start || auto_start) begin
          state_d     = ST_REQ_ID;
          id_mis_d    = 1'b0;
          ts_mis_d    = 1'b0;
          timeout_d   = 1'b0;
          retry_clear = 1'b1;
        end
      end
      ST_REQ_ID, ST_WAIT_ID, ST_REQ_TS, ST_WAIT_TS: begin
        // Data/acceptance wins over expiry on the transaction's last cycle.
        if ((state == ST_REQ_ID) && !avm_waitrequest) begin
          state_d = ST_WAIT_ID;
        end else if ((state == ST_REQ_TS) && !avm_waitrequest) begin
          state_d = ST_WAIT_TS;
        end else if ((state == ST_WAIT_ID) && avm_readdatavalid) begin
          cap_id      = 1'b1;
          id_mis_d    = (avm_readdata != EXPECTED_ID);
          retry_clear = 1'b1;
          state_d     = ST_REQ_TS;
        end else if ((state == ST_WAIT_TS) && avm_readdatavalid) begin
          cap_ts   = 1'b1;
          ts_mis_d = (avm_readdata != EXPECTED_TIMESTAMP);
          state_d  = ST_DONE;
        end else if (expired) begin
          if (exhausted) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            retry_inc = 1'b1;
            state_d   = ((state == ST_REQ_ID) || (state == ST_WAIT_ID)) ? ST_REQ_ID : ST_REQ_TS;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cnt_en    = (state != ST_IDLE) && (state != ST_DONE);
  assign cnt_clear = retry_inc ||
                     (((state_d == ST_REQ_ID) || (state_d == ST_REQ_TS)) && (state_d != state));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      auto_start  <= 1'b1;
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      read_id     <= '0;
      read_ts     <= '0;
    end else begin
      state       <= state_d;
      if (state == ST_IDLE) auto_start <= 1'b0;
      avm_read    <= (state_d == ST_REQ_ID) || (state_d == ST_REQ_TS);
      if (state_d == ST_REQ_ID) avm_address <= ADDR_ID;
      else if (state_d == ST_REQ_TS) avm_address <= ADDR_TS;
      busy        <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done        <= (state_d == ST_DONE);
      pass        <= (state_d == ST_DONE) && !id_mis_d && !ts_mis_d && !timeout_d;
      id_mismatch <= id_mis_d;
      ts_mismatch <= ts_mis_d;
      timeout     <= timeout_d;
      if (cap_id) read_id <= avm_readdata;
      if (cap_ts) read_ts <= avm_readdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_de2_115_sopc_sysid_checker.sv
// tb_de2_115_sopc_sysid_checker: directed scenarios against a behavioural sysid
// slave; a scoreboard monitor checks each completed run when done rises.
`default_nettype none

module tb_de2_115_sopc_sysid_checker;

  localparam logic [31:0] TS_VAL = 32'd1354258592;

  typedef struct {
    logic [3:0]  flags;   // {pass, id_mismatch, ts_mismatch, timeout}
    logic [31:0] rid;
    logic [31:0] rts;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n, start;
  logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] read_id, read_ts;

  int checks = 0;
  int passes = 0;
  exp_t exp_q[$];

  // slave configuration and bookkeeping
  int          stall_cfg = 0, stall_left = 0, latency = 1, pend = 0;
  logic [31:0] id_val = 32'd0, pend_data = 32'd0;
  logic        drop_ts = 1'b0, stray_req = 1'b0, in_stall = 1'b0, stall_addr = 1'b0;
  int          ts_accepts = 0;
  logic        done_q = 1'b0;

  de2_115_sopc_sysid_checker #(
    .TIMEOUT_CYCLES(8),
    .MAX_RETRIES   (2)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .id_mismatch      (id_mismatch),
    .ts_mismatch      (ts_mismatch),
    .timeout          (timeout),
    .read_id          (read_id),
    .read_ts          (read_ts)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  // Behavioural slave: drives its inputs on the falling edge.
  always @(negedge clock) begin
    avm_readdatavalid = 1'b0;
    if (!reset_n) begin
      pend            = 0;
      stall_left      = stall_cfg;
      in_stall        = 1'b0;
      stray_req       = 1'b0;
      avm_waitrequest = 1'b0;
    end else begin
      if (stray_req) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEADBEEF;
        stray_req         = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_data;
        end
      end
      if (in_stall) check("stall_stable", {30'd0, avm_read, avm_address}, {30'd0, 1'b1, stall_addr});
      if (avm_read) begin
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
          in_stall   = 1'b1;
          stall_addr = avm_address;
        end else begin
          avm_waitrequest = 1'b0;
          in_stall        = 1'b0;
          stall_left      = stall_cfg;
          if (avm_address) begin
            ts_accepts++;
            if (!drop_ts) begin pend = latency; pend_data = TS_VAL; end
          end else begin
            pend = latency; pend_data = id_val;
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
        in_stall        = 1'b0;
      end
    end
  end

  // Scoreboard monitor: each rising done consumes one expected result.
  always @(negedge clock) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_flags", {28'd0, pass, id_mismatch, ts_mismatch, timeout}, {28'd0, e.flags});
        check("read_id", read_id, e.rid);
        check("read_ts", read_ts, e.rts);
      end
    end
    done_q <= done;
  end

  task automatic push(input logic [3:0] flags, input logic [31:0] rid, input logic [31:0] rts);
    exp_t e;
    e.flags = flags; e.rid = rid; e.rts = rts;
    exp_q.push_back(e);
  endtask

  // Counts rising edges until done is seen; releases start after the first edge.
  task automatic wait_done(input string name, input int expect_cycles);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      n++;
      if (done) begin seen = 1; break; end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    else check({name, "_cycles"}, n, expect_cycles);
  endtask

  task automatic cfg(input int stall, input int lat, input logic [31:0] idv, input logic drop);
    stall_cfg = stall; stall_left = stall; latency = lat; id_val = idv; drop_ts = drop;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit hit;
    reset_n = 1'b0;
    start   = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_ctrl", {24'd0, avm_read, avm_address, busy, done, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
    check("reset_read_ts", read_ts, 32'd0);

    // 1: auto-start after reset, best case
    cfg(0, 1, 32'd0, 1'b0);
    push(4'b1000, 32'd0, TS_VAL);
    reset_n = 1'b1;
    wait_done("t1", 5);

    // 2: ID mismatch, timestamp still read
    cfg(0, 1, 32'd7, 1'b0);
    push(4'b0100, 32'd7, TS_VAL);
    start = 1'b1;
    wait_done("t2", 5);

    // 3: 3 stall cycles, latency 4 on each word
    cfg(3, 4, 32'd0, 1'b0);
    push(4'b1000, 32'd0, TS_VAL);
    start = 1'b1;
    wait_done("t3", 17);

    // 4: timestamp never returns -> 3 attempts, timeout
    cfg(0, 1, 32'd0, 1'b1);
    base = ts_accepts;
    push(4'b0001, 32'd0, TS_VAL);
    start = 1'b1;
    wait_done("t4", 27);
    check("t4_ts_requests", ts_accepts - base, 32'd3);

    // 5: stray data in DONE is ignored, then a clean rerun
    cfg(0, 1, 32'd0, 1'b0);
    stray_req = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("t5_stray_read_ts", read_ts, TS_VAL);
    check("t5_stray_read_id", read_id, 32'd0);
    check("t5_stray_flags", {28'd0, done, pass, ts_mismatch, timeout}, {28'd0, 4'b1001});
    push(4'b1000, 32'd0, TS_VAL);
    start = 1'b1;
    wait_done("t5", 5);

    // 6: reset pulse during WAIT_TS, then automatic rerun
    cfg(0, 4, 32'd0, 1'b0);
    base = ts_accepts;
    start = 1'b1;
    hit = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      if (ts_accepts != base) begin hit = 1; break; end
    end
    check("t6_reach_wait_ts", {31'd0, hit}, 32'd1);
    check("t6_busy_before_reset", {31'd0, busy}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_async_reset_ctrl", {24'd0, avm_read, avm_address, busy, done, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
    check("t6_async_reset_data", read_id | read_ts, 32'd0);
    @(posedge clock);
    #1;
    cfg(0, 1, 32'd0, 1'b0);
    push(4'b1000, 32'd0, TS_VAL);
    reset_n = 1'b1;
    wait_done("t6", 5);

    repeat (2) @(posedge clock);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
